// File: rtl/periferic_pkg.sv
// Shared types and frame geometry for the serial DAC peripheral.
package periferic_pkg;

  localparam int DAC_ADDR_W     = 3;
  localparam int DAC_DATA_W     = 8;
  localparam int DAC_FRAME_BITS = DAC_ADDR_W + DAC_DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LOAD  = 2'd3
  } dac_state_t;

  function automatic logic [DAC_FRAME_BITS-1:0] dac_frame(
    input logic [DAC_ADDR_W-1:0] addr,
    input logic [DAC_DATA_W-1:0] data
  );
    return {addr, data};
  endfunction

endpackage

// File: rtl/periferic_dac_bit_timer.sv
// Phase timer for the DAC serial clock: counts CLK_DIV cycles per phase and
// toggles the phase bit at every phase boundary.
module dac_bit_timer #(
  parameter  int CLK_DIV = 79,
  localparam int CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  output logic             half_tick,
  output logic             phase,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] TICK_CNT = CNT_W'(CLK_DIV - 1);

  logic             phase_r;
  logic [CNT_W-1:0] count_r;

  assign half_tick = (count_r == TICK_CNT);
  assign phase     = phase_r;
  assign count     = count_r;

  // Counter restarts at each phase boundary so bit periods never drift.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      count_r <= '0;
      phase_r <= 1'b0;
    end else if (half_tick) begin
      count_r <= '0;
      phase_r <= ~phase_r;
    end else begin
      count_r <= count_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/periferic_dac.sv
// Round-robin refresh of an 8-channel serial DAC: 3-bit address + 8 data bits,
// MSB first, committed by an active-low load strobe.
module periferic_dac #(
  parameter int CLK_DIV    = 79,
  parameter int N_CHANNELS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] data_input,
  input  logic [7:0]  data_channel0,
  input  logic [7:0]  data_channel1,
  input  logic [7:0]  data_channel2,
  input  logic [7:0]  data_channel3,
  input  logic [7:0]  data_channel4,
  input  logic [7:0]  data_channel5,
  input  logic [7:0]  data_channel6,
  input  logic [7:0]  data_channel7,
  output logic        dac_sclk,
  output logic        dac_sdata,
  output logic        dac_load_n,
  output logic [2:0]  current_channel,
  output logic        busy,
  output logic        frame_done
);
  import periferic_pkg::*;

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic             LAST_PH  = (CLK_DIV == 1) ? 1'b0 : 1'b1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((CLK_DIV == 1) ? 0 : CLK_DIV - 2);
  localparam logic [3:0]       LAST_BIT = 4'(DAC_FRAME_BITS - 1);
  localparam logic [2:0]       LAST_CH  = 3'(N_CHANNELS - 1);

  dac_state_t                state_r, state_nxt_s;
  logic                      enable_dac_r;
  logic [DAC_FRAME_BITS-1:0] shift_r;
  logic [3:0]                bit_cnt_r;
  logic [2:0]                channel_r;
  logic                      sclk_r, load_n_r, busy_r, frame_done_r;
  logic [7:0]                chan_data_s;
  logic                      restart_s, half_tick_s, phase_s, phase_nxt_s;
  logic                      period_end_s, pre_last_s;
  logic [CNT_W-1:0]          count_s;
  logic                      unused_s;

  assign unused_s = ^data_input[31:1];

  dac_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .restart   (restart_s),
    .half_tick (half_tick_s),
    .phase     (phase_s),
    .count     (count_s)
  );

  assign restart_s    = (state_r == ST_IDLE) || (state_r == ST_LATCH);
  assign period_end_s = half_tick_s && phase_s;
  // Flags the cycle before the final LOAD cycle so frame_done can be registered.
  assign pre_last_s   = (state_r == ST_LOAD) && (phase_s == LAST_PH) && (count_s == LAST_CNT);

  always_comb begin
    chan_data_s = 8'h00;
    case (channel_r)
      3'd0:    chan_data_s = data_channel0;
      3'd1:    chan_data_s = data_channel1;
      3'd2:    chan_data_s = data_channel2;
      3'd3:    chan_data_s = data_channel3;
      3'd4:    chan_data_s = data_channel4;
      3'd5:    chan_data_s = data_channel5;
      3'd6:    chan_data_s = data_channel6;
      3'd7:    chan_data_s = data_channel7;
      default: chan_data_s = 8'h00;
    endcase
  end

  always_comb begin
    state_nxt_s = state_r;
    phase_nxt_s = phase_s;
    if (restart_s) begin
      phase_nxt_s = 1'b0;
    end else if (half_tick_s) begin
      phase_nxt_s = ~phase_s;
    end else begin
      phase_nxt_s = phase_s;
    end
    case (state_r)
      ST_IDLE:  state_nxt_s = enable_dac_r ? ST_LATCH : ST_IDLE;
      ST_LATCH: state_nxt_s = ST_SHIFT;
      ST_SHIFT: begin
        if (period_end_s && (bit_cnt_r == 4'd0)) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_LOAD: begin
        if (frame_done_r) begin
          state_nxt_s = enable_dac_r ? ST_LATCH : ST_IDLE;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      enable_dac_r <= 1'b0;
      shift_r      <= '0;
      bit_cnt_r    <= 4'd0;
      channel_r    <= 3'd0;
      sclk_r       <= 1'b0;
      load_n_r     <= 1'b1;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      sclk_r       <= (state_nxt_s == ST_SHIFT) && phase_nxt_s;
      load_n_r     <= (state_nxt_s != ST_LOAD);
      busy_r       <= (state_nxt_s != ST_IDLE);
      frame_done_r <= pre_last_s;
      if (enable) begin
        enable_dac_r <= data_input[0];
      end
      case (state_r)
        ST_LATCH: begin
          shift_r   <= dac_frame(channel_r, chan_data_s);
          bit_cnt_r <= LAST_BIT;
        end
        ST_SHIFT: begin
          if (period_end_s) begin
            shift_r <= {shift_r[DAC_FRAME_BITS-2:0], 1'b0};
            if (bit_cnt_r != 4'd0) begin
              bit_cnt_r <= bit_cnt_r - 4'd1;
            end
          end
        end
        default: ;
      endcase
      if (frame_done_r) begin
        channel_r <= (channel_r == LAST_CH) ? 3'd0 : channel_r + 3'd1;
      end
    end
  end

  assign dac_sclk        = sclk_r;
  assign dac_sdata       = shift_r[DAC_FRAME_BITS-1];
  assign dac_load_n      = load_n_r;
  assign current_channel = channel_r;
  assign busy            = busy_r;
  assign frame_done      = frame_done_r;

endmodule

// File: tb/tb_periferic_dac.sv
// Directed bench for periferic_dac at CLK_DIV=2: decodes DAC frames from the
// serial pins and compares them against hand-computed values.
module tb_periferic_dac;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [31:0] data_input;
  logic [7:0]  ch0, ch1, ch2, ch3, ch4, ch5, ch6, ch7;
  logic        dac_sclk, dac_sdata, dac_load_n, busy, frame_done;
  logic [2:0]  current_channel;

  periferic_dac #(.CLK_DIV(2), .N_CHANNELS(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .data_input      (data_input),
    .data_channel0   (ch0),
    .data_channel1   (ch1),
    .data_channel2   (ch2),
    .data_channel3   (ch3),
    .data_channel4   (ch4),
    .data_channel5   (ch5),
    .data_channel6   (ch6),
    .data_channel7   (ch7),
    .dac_sclk        (dac_sclk),
    .dac_sdata       (dac_sdata),
    .dac_load_n      (dac_load_n),
    .current_channel (current_channel),
    .busy            (busy),
    .frame_done      (frame_done)
  );

  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame decoder on the serial pins
  int          cyc = 0;
  logic        prev_sclk = 1'b0;
  logic [10:0] cap = 11'd0;
  int          nbits = 0, nload = 0, nf = 0, sclk_rises = 0, load_low = 0;
  logic [10:0] frames [0:31];
  int          fbits  [0:31];
  int          floads [0:31];
  int          fcyc   [0:31];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    prev_sclk <= dac_sclk;
    if (dac_sclk && !prev_sclk) sclk_rises <= sclk_rises + 1;
    if (!dac_load_n) load_low <= load_low + 1;
    if (frame_done && nf < 32) begin
      frames[nf] <= cap;
      fbits[nf]  <= nbits;
      floads[nf] <= nload + (dac_load_n ? 0 : 1);
      fcyc[nf]   <= cyc;
      nf         <= nf + 1;
      cap        <= 11'd0;
      nbits      <= 0;
      nload      <= 0;
    end else begin
      if (dac_sclk && !prev_sclk) begin
        cap   <= {cap[9:0], dac_sdata};
        nbits <= nbits + 1;
      end
      if (!dac_load_n) nload <= nload + 1;
    end
  end

  task automatic wait_frames(input int n, input int budget);
    for (int k = 0; k < budget && nf < n; k++) begin
      @(negedge clk);
      #1;
    end
    check_value($sformatf("frames_reached_%0d", n), nf, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  int e0, r0, l0, n0;

  initial begin
    reset = 1'b1; enable = 1'b0; data_input = 32'd0;
    ch0 = 8'hA5; ch1 = 8'h11; ch2 = 8'h22; ch3 = 8'h33;
    ch4 = 8'h44; ch5 = 8'h55; ch6 = 8'h66; ch7 = 8'h77;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    check_value("rst_sclk",  dac_sclk, 0);
    check_value("rst_sdata", dac_sdata, 0);
    check_value("rst_load_n", dac_load_n, 1);
    check_value("rst_chan",  current_channel, 0);
    check_value("rst_busy",  busy, 0);
    check_value("rst_done",  frame_done, 0);

    // 1: first frame, latency and length
    enable = 1'b1; data_input = 32'd1;
    @(posedge clk); #1;
    e0 = cyc; enable = 1'b0; data_input = 32'd0;
    check_value("t1_busy_c0", busy, 0);
    @(posedge clk); #1;
    check_value("t1_busy_latch", busy, 1);
    check_value("t1_sclk_latch", dac_sclk, 0);
    @(posedge clk); #1;
    check_value("t1_sdata_c2", dac_sdata, 0);
    check_value("t1_sclk_c2", dac_sclk, 0);
    @(posedge clk); @(posedge clk); #1;
    check_value("t1_sclk_c4", dac_sclk, 1);
    wait_frames(1, 100);
    check_value("t1_frame", frames[0], {21'd0, 3'd0, 8'hA5});
    check_value("t1_bits", fbits[0], 11);
    check_value("t1_load_len", floads[0], 4);
    check_value("t1_done_cycle", fcyc[0] - e0, 49);
    @(posedge clk); #1;
    check_value("t1_chan_next", current_channel, 1);

    // 2: full scan and wrap
    wait_frames(8, 8 * 49 + 50);
    ch0 = 8'h00; ch1 = 8'h00;
    for (int i = 1; i < 8; i++)
      check_value($sformatf("t2_frame%0d", i), frames[i], {21'd0, 3'(i), 8'(i * 17)});
    check_value("t2_back_to_back", fcyc[1] - fcyc[0], 49);
    wait_frames(9, 100);
    check_value("t2_wrap_frame", frames[8], {21'd0, 3'd0, 8'h00});

    // 3: channel data changes mid-frame
    repeat (20) @(negedge clk);
    ch1 = 8'hFF;
    wait_frames(10, 100);
    check_value("t3_old_data", frames[9], {21'd0, 3'd1, 8'h00});
    wait_frames(18, 8 * 49 + 50);
    check_value("t3_ch0_again", frames[16], {21'd0, 3'd0, 8'h00});
    check_value("t3_new_data", frames[17], {21'd0, 3'd1, 8'hFF});

    // 4: scan disabled on the 3rd bit
    repeat (10) @(negedge clk);
    #1; enable = 1'b1; data_input = 32'd0;
    @(posedge clk); #1; enable = 1'b0;
    wait_frames(19, 100);
    check_value("t4_frame", frames[18], {21'd0, 3'd2, 8'h22});
    check_value("t4_bits", fbits[18], 11);
    check_value("t4_load_len", floads[18], 4);
    repeat (2) @(negedge clk); #1;
    check_value("t4_busy", busy, 0);
    check_value("t4_load_n", dac_load_n, 1);
    check_value("t4_chan", current_channel, 3);
    r0 = sclk_rises;
    repeat (60) @(negedge clk); #1;
    check_value("t4_no_sclk", sclk_rises, r0);
    check_value("t4_no_frames", nf, 19);

    // 5: resume, then reset during LOAD
    enable = 1'b1; data_input = 32'd1;
    @(posedge clk); #1; enable = 1'b0; data_input = 32'd0;
    wait_frames(20, 100);
    check_value("t5_resume", frames[19], {21'd0, 3'd3, 8'h33});
    @(negedge clk); #1;
    for (int k = 0; k < 100 && dac_load_n; k++) begin
      @(negedge clk); #1;
    end
    check_value("t5_load_seen", dac_load_n, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check_value("t5_load_n", dac_load_n, 1);
    check_value("t5_busy", busy, 0);
    check_value("t5_chan", current_channel, 0);
    check_value("t5_done", frame_done, 0);
    check_value("t5_sclk", dac_sclk, 0);
    l0 = load_low;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk); #1;
    check_value("t5_no_strobe", load_low, l0);
    check_value("t5_no_frame", nf, 20);

    // 6: enable pulse with scan off
    @(negedge clk);
    enable = 1'b1; data_input = 32'd0;
    @(posedge clk); #1; enable = 1'b0;
    r0 = sclk_rises; l0 = load_low; n0 = nf;
    repeat (40) @(negedge clk); #1;
    check_value("t6_sclk_edges", sclk_rises, r0);
    check_value("t6_strobes", load_low, l0);
    check_value("t6_frames", nf, n0);
    check_value("t6_busy", busy, 0);
    check_value("t6_sclk", dac_sclk, 0);
    check_value("t6_sdata", dac_sdata, 0);
    check_value("t6_load_n", dac_load_n, 1);
    check_value("t6_chan", current_channel, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
